// File: rtl/console_fifo_displayer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_fifo_displayer: memory-mapped character FIFO drained at a paced  |
// | rate into a shifting CHARS-wide display register.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef DISP_BASE
`define DISP_BASE 64'h0000_0000_1000_0000
`endif

module console_fifo_displayer #(
  parameter int          CHARS      = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter int          DRAIN_DIV  = 1024,
  parameter logic [63:0] BASE       = `DISP_BASE
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ren,
  input  logic [63:0]        raddr,
  input  logic               wen,
  input  logic [63:0]        waddr,
  input  logic [63:0]        wdata,
  input  logic [7:0]         wmask,
  output logic [63:0]        rdata,
  output logic               rvalid,
  output logic               wvalid,
  output logic [CHARS*8-1:0] display_o
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = c_AW + 1;
  localparam int c_PW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  localparam logic [c_PW-1:0] c_PACE_RELOAD = c_PW'(DRAIN_DIV - 1);
  localparam logic [c_CW-1:0] c_DEPTH       = c_CW'(FIFO_DEPTH);
  localparam logic [63:0]     c_STATUS_ADDR = BASE + 64'd8;
  localparam logic [63:0]     c_CTRL_ADDR   = BASE + 64'd16;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_PACE = 2'd1;
  localparam logic [1:0] c_POP  = 2'd2;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_count_nx;
  logic            r_ovf;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nx;
  logic [c_PW-1:0] r_pace;
  logic [7:0]      r_chars [CHARS];

  logic        w_full;
  logic        w_empty;
  logic        w_data_wr;
  logic        w_push;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_ovf_clr;
  logic        w_pop;
  logic        w_pace_load;
  logic        w_busy;
  logic [63:0] w_status;
  logic        w_unused;

  assign w_full     = (r_count == c_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_data_wr  = wen && (waddr == BASE) && wmask[0];
  // Fullness is judged before any same-cycle pop, so a pop never rescues a write.
  assign w_push     = w_data_wr && !w_full;
  assign w_ctrl_wr  = wen && (waddr == c_CTRL_ADDR);
  assign w_clear    = w_ctrl_wr && wdata[0];
  assign w_ovf_clr  = w_ctrl_wr && wdata[1];
  assign w_pop      = (r_state == c_POP) && !w_clear && !w_empty;
  assign w_count_nx = r_count + c_CW'(w_push) - c_CW'(w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      r_count <= w_count_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       r_ovf <= 1'b0;
    else if (w_data_wr && w_full)    r_ovf <= 1'b1;
    else if (w_ovf_clr)              r_ovf <= 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_IDLE;
      r_pace  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_pace_load)                           r_pace <= c_PACE_RELOAD;
      else if (r_state == c_PACE && r_pace != '0) r_pace <= r_pace - c_PW'(1);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_IDLE:  if (!w_empty) w_state_nx = c_PACE;
      c_PACE:  if (r_pace == '0) w_state_nx = c_POP;
      c_POP:   w_state_nx = (w_count_nx != '0) ? c_PACE : c_IDLE;
      default: w_state_nx = c_IDLE;
    endcase
    if (w_clear) w_state_nx = c_IDLE;
  end

  always_comb begin
    w_pace_load = w_clear || ((w_state_nx == c_PACE) && (r_state != c_PACE));
    w_busy      = (r_state != c_IDLE) || !w_empty;
  end

  // A clear takes priority over a pop landing on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CHARS; i++) r_chars[i] <= 8'h0F;
    end else if (w_clear) begin
      for (int i = 0; i < CHARS; i++) r_chars[i] <= 8'h0F;
    end else if (w_pop) begin
      for (int i = CHARS - 1; i > 0; i--) r_chars[i] <= r_chars[i-1];
      r_chars[0] <= r_mem[r_rptr];
    end
  end

  for (genvar gi = 0; gi < CHARS; gi++) begin : g_disp
    assign display_o[gi*8 +: 8] = r_chars[gi];
  end

  assign w_status = {w_busy, w_full, w_empty, r_ovf, 44'd0, 16'(r_count)};
  assign rdata    = (rstn && ren && (raddr == c_STATUS_ADDR)) ? w_status : 64'd0;
  assign rvalid   = 1'b1;
  assign wvalid   = 1'b1;
  assign w_unused = ^{wdata[63:8], wmask[7:1]};

endmodule

`default_nettype wire

// File: tb/tb_console_fifo_displayer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_console_fifo_displayer: randomized and directed bench for             |
// | console_fifo_displayer against a queue-based timing model.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_console_fifo_displayer;

  localparam int          CHARS  = 8;
  localparam int          DEPTH  = 4;
  localparam int          DIV    = 4;
  localparam logic [63:0] BASE   = 64'h0000_0000_2000_0000;
  localparam logic [63:0] A_DATA = BASE;
  localparam logic [63:0] A_STAT = BASE + 64'd8;
  localparam logic [63:0] A_CTRL = BASE + 64'd16;
  localparam logic [63:0] ALL_0F = {8{8'h0F}};

  logic               clk   = 1'b0;
  logic               rstn  = 1'b0;
  logic               ren   = 1'b0;
  logic [63:0]        raddr = '0;
  logic               wen   = 1'b0;
  logic [63:0]        waddr = '0;
  logic [63:0]        wdata = '0;
  logic [7:0]         wmask = '0;
  logic [63:0]        rdata;
  logic               rvalid;
  logic               wvalid;
  logic [CHARS*8-1:0] display_o;

  console_fifo_displayer #(
    .CHARS(CHARS), .FIFO_DEPTH(DEPTH), .DRAIN_DIV(DIV), .BASE(BASE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ren(ren), .raddr(raddr),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .rvalid(rvalid), .wvalid(wvalid),
    .display_o(display_o)
  );

  always #5 clk = ~clk;

  // Model: byte queue, display array, and the absolute edge of the next pop.
  logic [7:0] m_q[$];
  logic [7:0] m_chars [CHARS];
  logic       m_ovf;
  bit         m_sched;
  longint     m_sched_t;
  longint     m_t = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         chk_en  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_disp();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < CHARS; i++) v[i*8 +: 8] = m_chars[i];
    return v;
  endfunction

  function automatic logic [63:0] model_status();
    logic busy;
    busy = m_sched || (m_q.size() != 0);
    return {busy, m_q.size() == DEPTH, m_q.size() == 0, m_ovf, 44'd0, 16'(m_q.size())};
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < CHARS; i++) m_chars[i] = 8'h0F;
    m_ovf   = 1'b0;
    m_sched = 1'b0;
  endtask

  // Pops are spaced DIV+1 edges apart; a push into an idle empty FIFO is
  // first displayed DIV+2 edges later.
  task automatic model_edge();
    bit data_wr, ctrl_wr, do_pop, push_ok;
    m_t++;
    if (!rstn) return;
    data_wr = wen && (waddr == A_DATA) && wmask[0];
    ctrl_wr = wen && (waddr == A_CTRL);
    do_pop  = m_sched && (m_sched_t == m_t);
    if (ctrl_wr && wdata[0]) begin
      m_q.delete();
      for (int i = 0; i < CHARS; i++) m_chars[i] = 8'h0F;
      m_sched = 1'b0;
      do_pop  = 1'b0;
    end
    if (ctrl_wr && wdata[1]) m_ovf = 1'b0;
    push_ok = data_wr && (m_q.size() < DEPTH);
    if (data_wr && !push_ok) m_ovf = 1'b1;
    if (do_pop) begin
      for (int i = CHARS - 1; i > 0; i--) m_chars[i] = m_chars[i-1];
      m_chars[0] = m_q.pop_front();
    end
    if (push_ok) m_q.push_back(wdata[7:0]);
    if (do_pop) begin
      m_sched   = (m_q.size() != 0);
      m_sched_t = m_t + DIV + 1;
    end else if (!m_sched && m_q.size() != 0) begin
      m_sched   = 1'b1;
      m_sched_t = m_t + DIV + 2;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("display", display_o, model_disp());
      check("rdata", rdata, (rstn && ren && raddr == A_STAT) ? model_status() : 64'd0);
      check("valid", {62'd0, rvalid, wvalid}, 64'd3);
    end
  end

  task automatic cyc(input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] m, input logic r, input logic [63:0] ra);
    wen = w; waddr = a; wdata = d; wmask = m; ren = r; raddr = ra;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    cyc(1'b0, 64'd0, 64'd0, 8'd0, 1'b1, A_STAT);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    cyc(1'b1, a, d, 8'hFF, 1'b1, A_STAT);
  endtask

  initial begin
    logic [63:0] ra, wa;
    int          r;
    model_reset();
    ren = 1'b1; raddr = A_STAT;
    chk_en = 1'b1;
    repeat (3) idle();
    check("rst_display", display_o, ALL_0F);
    check("rst_rdata", rdata, 64'd0);
    rstn = 1'b1;
    idle();
    check("post_rst_status", rdata, 64'h2000_0000_0000_0000);

    // Single character latency
    wr(A_DATA, 64'h41);
    repeat (5) idle();
    check("lat_before", display_o, ALL_0F);
    idle();
    check("lat_at6", display_o, 64'h0F0F_0F0F_0F0F_0F41);
    check("lat_status", rdata, 64'h2000_0000_0000_0000);

    // Overflow on back-to-back writes
    for (int i = 0; i < 6; i++) begin
      wr(A_DATA, 64'h61 + 64'(i));
      if (i == 3) check("full_status", rdata, 64'hC000_0000_0000_0004);
    end
    check("ovf_status", rdata, 64'hD000_0000_0000_0004);
    repeat (25) idle();
    check("ovf_display", display_o, 64'h0F0F_0F41_6162_6364);
    check("ovf_drained", rdata, 64'h3000_0000_0000_0000);

    // Overflow clear leaves contents
    wr(A_DATA, 64'h31);
    wr(A_DATA, 64'h32);
    wr(A_CTRL, 64'h2);
    check("ovf_clr_status", rdata, 64'h8000_0000_0000_0002);
    repeat (15) idle();
    check("ovf_clr_display", display_o, 64'h0F41_6162_6364_3132);

    // Flush during pacing
    wr(A_DATA, 64'h51);
    wr(A_DATA, 64'h52);
    idle();
    wr(A_CTRL, 64'h1);
    check("flush_display", display_o, ALL_0F);
    check("flush_status", rdata, 64'h2000_0000_0000_0000);
    repeat (20) idle();
    check("flush_no_pop", display_o, ALL_0F);

    // Reset mid-pacing
    wr(A_DATA, 64'h81);
    wr(A_DATA, 64'h82);
    wr(A_DATA, 64'h83);
    idle();
    rstn = 1'b0;
    model_reset();
    #1;
    check("midrst_display", display_o, ALL_0F);
    check("midrst_rdata", rdata, 64'd0);
    idle();
    rstn = 1'b1;
    idle();
    check("midrst_status", rdata, 64'h2000_0000_0000_0000);
    repeat (20) idle();
    check("midrst_no_pop", display_o, ALL_0F);

    // Push coinciding with pop
    wr(A_DATA, 64'h71);
    wr(A_DATA, 64'h72);
    repeat (4) idle();
    wr(A_DATA, 64'h73);
    check("pushpop_status", rdata, 64'h8000_0000_0000_0002);
    repeat (20) idle();
    check("pushpop_order", {40'd0, display_o[23:0]}, 64'h0000_0000_0071_7273);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0:       ra = A_DATA;
        1:       ra = A_CTRL;
        2:       ra = BASE + 64'd24;
        default: ra = A_STAT;
      endcase
      r = $urandom_range(0, 99);
      if (r < 35) begin
        cyc(1'b1, A_DATA, {$urandom, $urandom},
            ($urandom_range(0, 4) == 0) ? 8'hFE : 8'hFF, ($urandom_range(0, 9) != 0), ra);
      end else if (r < 38) begin
        cyc(1'b1, A_CTRL, 64'($urandom_range(0, 3)), 8'hFF, 1'b1, ra);
      end else if (r < 43) begin
        wa = ($urandom_range(0, 1) == 0) ? A_STAT : BASE + 64'd4;
        cyc(1'b1, wa, 64'($urandom), 8'hFF, 1'b1, ra);
      end else if (r == 99 && $urandom_range(0, 3) == 0) begin
        rstn = 1'b0;
        model_reset();
        idle();
        rstn = 1'b1;
      end else begin
        cyc(1'b0, 64'd0, 64'd0, 8'd0, ($urandom_range(0, 9) != 0), ra);
      end
    end

    repeat (2) idle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
